// File: rtl/k007232_cmd_seq.sv
// Host-side command sequencer for the 007232 register port: expands one channel
// command into an ordered register write burst, skipping writes that match shadows.
module k007232_cmd_seq #(
    parameter int STB_LEN = 2,
    parameter bit SKIP_EN = 1'b1
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST_n,
    input  logic        i_CEN,
    input  logic        i_CMD_VALID,
    output logic        o_CMD_READY,
    input  logic        i_CMD_CH,
    input  logic [16:0] i_CMD_ADDR,
    input  logic [11:0] i_CMD_PRE,
    input  logic [1:0]  i_CMD_MODE,
    input  logic        i_CMD_LOOP,
    input  logic [3:0]  i_CMD_VOL,
    input  logic        i_CMD_NOTRIG,
    output logic        o_DACS_n,
    output logic [3:0]  o_AB,
    output logic [7:0]  o_DB,
    output logic        o_BUSY,
    output logic        o_DONE
);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t      state_q;
    logic [3:0]  idx_q, cnt_q;
    logic        dacs_q, ready_q, busy_q, done_q;
    logic [3:0]  ab_q;
    logic [7:0]  db_q;

    // command latched at accept
    logic        ch_q, loop_q, notrig_q;
    logic [16:0] addr_q;
    logic [11:0] pre_q;
    logic [1:0]  mode_q;
    logic [3:0]  vol_q;

    // slots 0-4: ch A regs 0,1,2,3,5; 5-9: ch B regs 6,7,8,9,B; 10: regC; 11: regD
    logic [7:0]  sh_q [0:11];
    logic [11:0] shv_q;
    logic [1:0]  lp_q, lpv_q, vlv_q;
    logic [3:0]  vl_q [0:1];

    logic        loop_a, loop_b, skip_d;
    logic [3:0]  vol_a, vol_b, off_d, base_d, slot_d, ab_d;
    logic [7:0]  db_d;

    always_comb begin
        loop_a = ch_q ? (lp_q[0] & lpv_q[0]) : loop_q;
        loop_b = ch_q ? loop_q : (lp_q[1] & lpv_q[1]);
        vol_a  = ch_q ? (vlv_q[0] ? vl_q[0] : 4'h0) : vol_q;
        vol_b  = ch_q ? vol_q : (vlv_q[1] ? vl_q[1] : 4'h0);
        off_d  = ch_q ? 4'd6 : 4'd0;
        base_d = ch_q ? 4'd5 : 4'd0;
        slot_d = base_d + {1'b0, idx_q[2:0]};
        ab_d   = off_d + 4'd4;
        db_d   = 8'h00;
        case (idx_q[2:0])
            3'd0: begin ab_d = off_d;         db_d = {2'b00, mode_q, pre_q[11:8]}; end
            3'd1: begin ab_d = off_d + 4'd1;  db_d = pre_q[7:0];                   end
            3'd2: begin ab_d = off_d + 4'd2;  db_d = addr_q[15:8];                 end
            3'd3: begin ab_d = off_d + 4'd3;  db_d = addr_q[7:0];                  end
            3'd4: begin ab_d = off_d + 4'd5;  db_d = {7'b0, addr_q[16]};           end
            3'd5: begin ab_d = 4'hC; db_d = {6'b0, loop_b, loop_a}; slot_d = 4'd10; end
            3'd6: begin ab_d = 4'hD; db_d = {vol_a, vol_b};         slot_d = 4'd11; end
            default: slot_d = 4'd0;
        endcase
        if (idx_q[2:0] == 3'd7)
            skip_d = notrig_q;
        else
            skip_d = SKIP_EN && shv_q[slot_d] && (sh_q[slot_d] == db_d);
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            dacs_q  <= 1'b1;
            ab_q    <= 4'd0;
            db_q    <= 8'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            shv_q   <= '0;
            lpv_q   <= '0;
            vlv_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (i_CMD_VALID) begin
                    ch_q     <= i_CMD_CH;
                    addr_q   <= i_CMD_ADDR;
                    pre_q    <= i_CMD_PRE;
                    mode_q   <= i_CMD_MODE;
                    loop_q   <= i_CMD_LOOP;
                    vol_q    <= i_CMD_VOL;
                    notrig_q <= i_CMD_NOTRIG;
                    idx_q    <= 4'd0;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b1;
                    state_q  <= S_SCAN;
                end
                S_SCAN: begin
                    if (idx_q[3]) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (skip_d) begin
                        // a skip-equal on regC/regD still confirms this channel's loop/vol
                        if (idx_q[2:0] == 3'd5) begin
                            lp_q[ch_q]  <= loop_q;
                            lpv_q[ch_q] <= 1'b1;
                        end
                        if (idx_q[2:0] == 3'd6) begin
                            vl_q[ch_q]  <= vol_q;
                            vlv_q[ch_q] <= 1'b1;
                        end
                        idx_q <= idx_q + 4'd1;
                    end else begin
                        ab_q    <= ab_d;
                        db_q    <= db_d;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: if (i_CEN) begin
                    dacs_q  <= 1'b0;
                    cnt_q   <= 4'd0;
                    state_q <= S_STROBE;
                end
                S_STROBE: if (i_CEN) begin
                    if (cnt_q == 4'(STB_LEN - 1)) begin
                        dacs_q  <= 1'b1;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_HOLD: if (i_CEN) begin
                    if (idx_q[2:0] != 3'd7) begin
                        sh_q[slot_d]  <= db_q;
                        shv_q[slot_d] <= 1'b1;
                    end
                    if (idx_q[2:0] == 3'd5) begin
                        lp_q[ch_q]  <= loop_q;
                        lpv_q[ch_q] <= 1'b1;
                    end
                    if (idx_q[2:0] == 3'd6) begin
                        vl_q[ch_q]  <= vol_q;
                        vlv_q[ch_q] <= 1'b1;
                    end
                    idx_q   <= idx_q + 4'd1;
                    state_q <= S_SCAN;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_CMD_READY = ready_q;
    assign o_DACS_n    = dacs_q;
    assign o_AB        = ab_q;
    assign o_DB        = db_q;
    assign o_BUSY      = busy_q;
    assign o_DONE      = done_q;

endmodule

// File: tb/tb_k007232_cmd_seq.sv
// Directed bench for k007232_cmd_seq: table of commands with expected write bursts,
// plus hand sequences for idle-after-reset and reset during a strobe.
module tb_k007232_cmd_seq;

    logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b1, valid = 1'b0;
    logic        ch = 1'b0, loop = 1'b0, notrig = 1'b0;
    logic [16:0] addr = '0;
    logic [11:0] pre = '0;
    logic [1:0]  mode = '0;
    logic [3:0]  vol = '0;
    logic        ready, dacs_n, busy, done;
    logic [3:0]  ab;
    logic [7:0]  db;

    k007232_cmd_seq #(.STB_LEN(2), .SKIP_EN(1'b1)) dut (
        .i_EMUCLK(clk), .i_RST_n(rst_n), .i_CEN(cen),
        .i_CMD_VALID(valid), .o_CMD_READY(ready), .i_CMD_CH(ch),
        .i_CMD_ADDR(addr), .i_CMD_PRE(pre), .i_CMD_MODE(mode),
        .i_CMD_LOOP(loop), .i_CMD_VOL(vol), .i_CMD_NOTRIG(notrig),
        .o_DACS_n(dacs_n), .o_AB(ab), .o_DB(db), .o_BUSY(busy), .o_DONE(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // bus tick enable: high one cycle in every cen_div
    int cen_div = 1, cen_cnt = 0;
    always @(negedge clk) begin
        cen_cnt++;
        cen = ((cen_cnt % cen_div) == 0);
    end

    // write-burst monitor, sampled 1 time unit after each rising edge
    logic [3:0] cap_ab [$];
    logic [7:0] cap_db [$];
    int         cap_len [$];
    bit         cap_st [$];
    int         done_cnt = 0;
    bit         in_low = 0, c_st;
    logic [3:0] c_ab;
    logic [7:0] c_db;
    int         c_len;
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
        if (dacs_n === 1'b0) begin
            if (!in_low) begin
                in_low = 1; c_ab = ab; c_db = db; c_len = 0; c_st = 1;
            end
            c_len++;
            if (ab !== c_ab || db !== c_db) c_st = 0;
        end else if (in_low) begin
            in_low = 0;
            cap_ab.push_back(c_ab); cap_db.push_back(c_db);
            cap_len.push_back(c_len); cap_st.push_back(c_st);
        end
    end

    typedef struct {
        logic        ch;
        logic [16:0] addr;
        logic [11:0] pre;
        logic [1:0]  mode;
        logic        loop;
        logic [3:0]  vol;
        logic        notrig;
        int          div;
        int          n;
        logic [7:0][3:0] ab;
        logic [7:0][7:0] db;
        int          len;
    } vec_t;

    function automatic vec_t mk(input logic c, input logic [16:0] a, input logic [11:0] p,
                                input logic [1:0] m, input logic l, input logic [3:0] v,
                                input logic nt, input int dv, input int n,
                                input logic [31:0] abs, input logic [63:0] dbs, input int len);
        vec_t r;
        r.ch = c; r.addr = a; r.pre = p; r.mode = m; r.loop = l; r.vol = v; r.notrig = nt;
        r.div = dv; r.n = n; r.ab = abs; r.db = dbs; r.len = len;
        return r;
    endfunction

    task automatic drive_cmd(input vec_t v);
        ch = v.ch; addr = v.addr; pre = v.pre; mode = v.mode;
        loop = v.loop; vol = v.vol; notrig = v.notrig;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int t, d0, nw;
        cap_ab.delete(); cap_db.delete(); cap_len.delete(); cap_st.delete();
        cen_div = v.div;
        @(negedge clk);
        drive_cmd(v);
        valid = 1'b1;
        t = 0;
        while (ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        d0 = done_cnt;
        @(negedge clk);
        valid = 1'b0;
        // scramble inputs: the burst must use the latched command
        ch = ~v.ch; addr = 17'($urandom); pre = 12'($urandom); mode = ~v.mode;
        loop = ~v.loop; vol = ~v.vol; notrig = ~v.notrig;
        check({tag, " busy_after_accept"}, busy, 1);
        check({tag, " ready_after_accept"}, ready, 0);
        t = 0;
        while (busy === 1'b1 && t < 3000) begin @(negedge clk); t++; end
        check({tag, " burst_timeout"}, t < 3000, 1);
        repeat (4) @(negedge clk);
        check({tag, " done_pulses"}, done_cnt - d0, 1);
        check({tag, " ready_idle"}, ready, 1);
        nw = cap_ab.size();
        check({tag, " write_count"}, nw, v.n);
        for (int i = 0; i < v.n && i < nw; i++) begin
            check($sformatf("%s w%0d AB", tag, i), cap_ab[i], v.ab[i]);
            check($sformatf("%s w%0d DB", tag, i), cap_db[i], v.db[i]);
            check($sformatf("%s w%0d low_len", tag, i), cap_len[i], v.len);
            check($sformatf("%s w%0d stable", tag, i), cap_st[i], 1);
        end
    endtask

    vec_t tab [5];

    initial begin
        int t;
        // ch A full burst; identical repeat; repeat without trigger; ch B full burst;
        // ch A volume change with CEN 1-in-4 (only regD and trigger differ)
        tab[0] = mk(0, 17'h12345, 12'hABC, 2'b01, 1, 4'h9, 0, 1, 8,
                    32'h4DC53210, 64'h00_90_01_01_45_23_BC_1A, 2);
        tab[1] = mk(0, 17'h12345, 12'hABC, 2'b01, 1, 4'h9, 0, 1, 1,
                    32'h4, 64'h00, 2);
        tab[2] = mk(0, 17'h12345, 12'hABC, 2'b01, 1, 4'h9, 1, 1, 0,
                    32'h0, 64'h00, 2);
        tab[3] = mk(1, 17'h00100, 12'h001, 2'b00, 1, 4'h5, 0, 1, 8,
                    32'hADCB9876, 64'h00_95_03_00_00_01_01_00, 2);
        tab[4] = mk(0, 17'h12345, 12'hABC, 2'b01, 1, 4'h3, 0, 4, 2,
                    32'h4D, 64'h00_35, 8);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset AB", ab, 0);
        check("reset DB", db, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d DACS_n", i), dacs_n, 1);
            check($sformatf("idle%0d READY", i), ready, 1);
            check($sformatf("idle%0d BUSY", i), busy, 0);
        end
        check("idle DONE pulses", done_cnt, 0);

        for (int k = 0; k < 5; k++) run_vec(tab[k], $sformatf("vec%0d", k));

        // reset while DACS_n is low abandons the burst and clears all shadows
        cen_div = 1;
        @(negedge clk);
        drive_cmd(tab[0]);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        t = 0;
        while (dacs_n !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        check("rst_mid strobe_seen", t < 200, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid DACS_n", dacs_n, 1);
        check("rst_mid READY", ready, 1);
        check("rst_mid BUSY", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(tab[0], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
